// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional trailer checksum: define IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        DONE,
        ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        CK_HI,
        CK_LO
`endif
    } state_t;

    localparam int HDR_BYTES = 2;
    localparam int TRL_BYTES = 2;
    localparam logic [15:0] ADDR_STEP = 16'h0002;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = stream source / memory side.
interface imem_loader_if;

    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_wr_en;
    logic [15:0] imem_wr_addr;
    logic [15:0] imem_wr_data;

    modport master (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output imem_wr_en,
        output imem_wr_addr,
        output imem_wr_data
    );

    modport slave (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  imem_wr_en,
        input  imem_wr_addr,
        input  imem_wr_data
    );

endinterface

// File: rtl/imem_loader_byte_pair_assembler.sv
// Collects a high byte then a low byte into a 16-bit word.
// Shared by header, data and (IMEM_LOADER_CHECKSUM_EN) trailer parsing.
module byte_pair_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        load_hi,
    input  logic        load_lo,
    input  logic [7:0]  byte_in,
    output logic [15:0] pair,
    output logic [15:0] word,
    output logic        complete
);

    logic [7:0] hi_q;
    logic [7:0] lo_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi_q     <= 8'h00;
            lo_q     <= 8'h00;
            complete <= 1'b0;
        end else if (clear) begin
            hi_q     <= 8'h00;
            lo_q     <= 8'h00;
            complete <= 1'b0;
        end else if (load_hi) begin
            hi_q     <= byte_in;
            complete <= 1'b0;
        end else if (load_lo) begin
            lo_q     <= byte_in;
            complete <= 1'b1;
        end
    end

    // pair lets the FSM judge a word in the same cycle its low byte arrives
    assign pair = {hi_q, byte_in};
    assign word = {hi_q, lo_q};

endmodule

// File: rtl/imem_loader.sv
// Serial-stream instruction-memory loader holding the CPU until done.
// Optional trailer checksum: define IMEM_LOADER_CHECKSUM_EN.
import imem_loader_pkg::*;

module imem_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [15:0] BASE_ADDR   = 16'h0000
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    imem_loader_if.master bus,
    output logic cpu_hold,
    output logic done,
    output logic error
);

    localparam logic [16:0] DEPTH = 17'(DEPTH_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t LAST_STATE = CK_HI;
`else
    localparam state_t LAST_STATE = DONE;
`endif

    state_t      state_q;
    state_t      state_d;
    logic        ready;
    logic        accept;
    logic        start_load;
    logic        load_hi;
    logic        load_lo;
    logic [15:0] pair;
    logic [15:0] word;
    logic        complete;
    logic [15:0] addr_q;
    logic [15:0] n_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_inc;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [15:0] sum_q;
`endif

    assign accept     = bus.byte_valid && ready;
    assign start_load = start && (state_q == IDLE || state_q == DONE);
    assign cnt_inc    = cnt_q + 16'd1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign load_hi = accept && (state_q == HDR_HI || state_q == DATA_HI
                             || state_q == CK_HI);
    assign load_lo = accept && (state_q == HDR_LO || state_q == DATA_LO
                             || state_q == CK_LO);
`else
    assign load_hi = accept && (state_q == HDR_HI || state_q == DATA_HI);
    assign load_lo = accept && (state_q == HDR_LO || state_q == DATA_LO);
`endif

    byte_pair_assembler u_pair (
        .clock    (clock),
        .reset    (reset),
        .clear    (start_load),
        .load_hi  (load_hi),
        .load_lo  (load_lo),
        .byte_in  (bus.byte_in),
        .pair     (pair),
        .word     (word),
        .complete (complete)
    );

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) state_d = HDR_HI;
            end
            HDR_HI: begin
                ready = 1'b1;
                if (bus.byte_valid) state_d = HDR_LO;
            end
            HDR_LO: begin
                ready = 1'b1;
                if (bus.byte_valid) begin
                    if (pair == 16'h0000)
                        state_d = LAST_STATE;
                    else if ({1'b0, pair} > DEPTH)
                        state_d = ERR;
                    else
                        state_d = DATA_HI;
                end
            end
            DATA_HI: begin
                ready = 1'b1;
                if (bus.byte_valid) state_d = DATA_LO;
            end
            DATA_LO: begin
                ready = 1'b1;
                if (bus.byte_valid) state_d = WRITE;
            end
            WRITE: begin
                state_d = (cnt_inc == n_q) ? LAST_STATE : DATA_HI;
            end
            ERR: begin
                state_d = ERR;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CK_HI: begin
                ready = 1'b1;
                if (bus.byte_valid) state_d = CK_LO;
            end
            CK_LO: begin
                ready = 1'b1;
                if (bus.byte_valid)
                    state_d = (pair == sum_q) ? DONE : ERR;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= BASE_ADDR;
            n_q     <= 16'h0000;
            cnt_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (start_load) begin
                addr_q <= BASE_ADDR;
                cnt_q  <= 16'h0000;
            end else if (state_q == WRITE) begin
                addr_q <= addr_q + ADDR_STEP;
                cnt_q  <= cnt_inc;
            end
            if (accept && state_q == HDR_LO) n_q <= pair;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            sum_q <= 16'h0000;
        else if (start_load)
            sum_q <= 16'h0000;
        else if (state_q == WRITE)
            sum_q <= sum_q + word;
    end
`endif

    assign bus.byte_ready   = ready;
    assign bus.imem_wr_en   = (state_q == WRITE) && complete;
    assign bus.imem_wr_addr = addr_q;
    assign bus.imem_wr_data = word;

    assign cpu_hold = (state_q != DONE);
    assign done     = (state_q == DONE);
    assign error    = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader.
// Builds streams from word lists; also covers IMEM_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int          DEPTH = 256;
    localparam logic [15:0] BASE  = 16'h0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic cpu_hold;
    logic done;
    logic error;

    imem_loader_if bus ();

    imem_loader #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clock = ~clock;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] got_q[$];
    int          wr_burst = 0;
    logic        wr_prev = 1'b0;

    // write monitor: capture every strobe, flag back-to-back strobes
    always @(negedge clock) begin
        if (bus.imem_wr_en)
            got_q.push_back({bus.imem_wr_addr, bus.imem_wr_data});
        if (bus.imem_wr_en && wr_prev)
            wr_burst++;
        wr_prev <= bus.imem_wr_en;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(bus.byte_ready), 0);
        chk({tag, "_wren"}, 32'(bus.imem_wr_en), 0);
        chk({tag, "_addr"}, 32'(bus.imem_wr_addr), 32'(BASE));
        chk({tag, "_data"}, 32'(bus.imem_wr_data), 0);
        chk({tag, "_hold"}, 32'(cpu_hold), 1);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(error), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // present bytes at negedge; ready is a state decode, stable until posedge
    task automatic send(input logic [7:0] s[$], input int pct);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        while (idx < s.size() && guard < 4000) begin
            @(negedge clock);
            guard++;
            bus.byte_valid = ($urandom_range(99) < pct);
            bus.byte_in = bus.byte_valid ? s[idx] : 8'($urandom);
            if (bus.byte_valid && bus.byte_ready)
                idx++;
        end
        @(negedge clock);
        bus.byte_valid = 1'b0;
        bus.byte_in = 8'h00;
        if (idx < s.size())
            chk("send_timeout", 32'(idx), 32'(s.size()));
    endtask

    task automatic wait_end();
        int g;
        g = 0;
        while (!(done || error) && g < 200) begin
            @(negedge clock);
            g++;
        end
        chk("end_timeout", 32'(done | error), 1);
    endtask

    // reference: stream and expected outcome straight from the word list
    task automatic run_load(input int n, input logic [15:0] w[$],
                            input bit bad_ck, input int pct,
                            input bit tmg);
        logic [7:0]  s[$];
        logic [31:0] exp_q[$];
        logic [15:0] nn;
        logic [15:0] sum;
        logic [15:0] tr;
        bit          exp_err;
        nn = 16'(n);
        sum = 16'h0000;
        s.push_back(nn[15:8]);
        s.push_back(nn[7:0]);
        exp_err = (n > DEPTH);
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                s.push_back(w[i][15:8]);
                s.push_back(w[i][7:0]);
                exp_q.push_back({BASE + 16'(2 * i), w[i]});
                sum = sum + w[i];
            end
            if (CK) begin
                tr = bad_ck ? (sum ^ 16'h0100) : sum;
                s.push_back(tr[15:8]);
                s.push_back(tr[7:0]);
                exp_err = bad_ck;
            end
        end
        got_q.delete();
        wr_burst = 0;
        pulse_start();
        send(s, pct);
        if (tmg) begin
            chk("t1_wren", 32'(bus.imem_wr_en), 32'(!CK));
            chk("t1_done", 32'(done), 32'(CK));
            @(negedge clock);
            chk("t2_done", 32'(done), 1);
            chk("t2_hold", 32'(cpu_hold), 0);
        end
        wait_end();
        chk("n_writes", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("wr%0d", i), got_q[i], exp_q[i]);
        chk("done", 32'(done), 32'(!exp_err));
        chk("error", 32'(error), 32'(exp_err));
        chk("hold", 32'(cpu_hold), 32'(exp_err));
        chk("wr_burst", 32'(wr_burst), 0);
    endtask

    initial begin
        logic [15:0] w[$];
        logic [7:0]  s[$];
        logic [7:0]  part [7];
        int          n;

        bus.byte_valid = 1'b0;
        bus.byte_in = 8'h00;
        repeat (2) @(negedge clock);
        chk_reset("rst");
        reset = 1'b1;

        w.delete();
        w.push_back(16'h1234);
        w.push_back(16'hABCD);
        run_load(2, w, 1'b0, 100, 1'b1);

        w.delete();
        run_load(0, w, 1'b0, 100, 1'b0);

        run_load(257, w, 1'b0, 100, 1'b0);
        pulse_start();
        repeat (3) @(negedge clock);
        chk("err_sticky", 32'(error), 1);
        chk("err_ready", 32'(bus.byte_ready), 0);
        chk("err_hold", 32'(cpu_hold), 1);
        do_reset();

        part = '{8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33};
        s.delete();
        foreach (part[i]) s.push_back(part[i]);
        got_q.delete();
        pulse_start();
        send(s, 100);
        reset = 1'b0;
        #1;
        chk_reset("midrst");
        chk("mid_nwr", 32'(got_q.size()), 2);
        if (got_q.size() == 2) begin
            chk("mid_wr0", got_q[0], {BASE, 16'h1111});
            chk("mid_wr1", got_q[1], {BASE + 16'h0002, 16'h2222});
        end
        @(negedge clock);
        reset = 1'b1;
        w.delete();
        w.push_back(16'h5566);
        run_load(1, w, 1'b0, 100, 1'b0);

        w.delete();
        w.push_back(16'h1234);
        w.push_back(16'hABCD);
        run_load(2, w, 1'b0, 50, 1'b0);

        if (CK) begin
            run_load(2, w, 1'b1, 100, 1'b0);
            do_reset();
        end

        for (int t = 0; t < 14; t++) begin
            n = $urandom_range(0, 7);
            if ($urandom_range(5) == 0)
                n = 257 + $urandom_range(0, 300);
            w.delete();
            for (int i = 0; i < n && i < 8; i++)
                w.push_back(16'($urandom));
            run_load(n, w, 1'($urandom_range(1)), $urandom_range(30, 100),
                     1'b0);
            if (error)
                do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
